// File: rtl/shift_reg_univ.sv
// Universal shift register: shift/rotate left/right, parallel load,
// synchronous clear, serial out and a saturating fill counter.
module shift_reg_univ #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       load,
  input  logic [WIDTH-1:0]           d_load,
  input  logic                       en,
  input  logic [1:0]                 mode,
  input  logic                       d_in,
  output logic [WIDTH-1:0]           d_out,
  output logic                       s_out,
  output logic [$clog2(WIDTH+1)-1:0] cnt,
  output logic                       full
);

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] CMAX = CW'(WIDTH);

  if (WIDTH < 2) begin : g_bad_width
    $error("shift_reg_univ: WIDTH must be >= 2");
  end

  logic [CW-1:0] cnt_inc;

  // Serial fill count saturates once the whole register has been filled.
  assign cnt_inc = (cnt == CMAX) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      d_out <= RESET_VAL;
      s_out <= 1'b0;
      cnt   <= '0;
      full  <= 1'b0;
    end else if (load) begin
      d_out <= d_load;
      s_out <= 1'b0;
      cnt   <= CMAX;
      full  <= 1'b1;
    end else if (en) begin
      case (mode)
        2'b00: begin
          d_out <= {d_out[WIDTH-2:0], d_in};
          s_out <= d_out[WIDTH-1];
          cnt   <= cnt_inc;
          full  <= (cnt_inc == CMAX);
        end
        2'b01: begin
          d_out <= {d_in, d_out[WIDTH-1:1]};
          s_out <= d_out[0];
          cnt   <= cnt_inc;
          full  <= (cnt_inc == CMAX);
        end
        2'b10: begin
          d_out <= {d_out[WIDTH-2:0], d_out[WIDTH-1]};
          s_out <= d_out[WIDTH-1];
        end
        2'b11: begin
          d_out <= {d_out[0], d_out[WIDTH-1:1]};
          s_out <= d_out[0];
        end
        default: ;
      endcase
    end
  end

  always @(posedge clk) begin
    if (!reset && !clear && !load && en) begin
      assert (!$isunknown(mode))
        else $error("shift_reg_univ: unknown mode while enabled");
    end
  end

endmodule
